// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 6502C bus: local RAM with read wait states,
// a 4-register down-counting timer with interrupt, and 0xFF for unmapped reads.
module cpu_bus_responder #(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] PERIPH_BASE = 16'hD200
) (
    input  logic       phi2,
    input  logic       rstAll,
    input  logic [7:0] extABH,
    input  logic [7:0] extABL,
    input  logic       RW,
    input  logic [7:0] extDB_in,
    output logic [7:0] extDB_out,
    output logic       extDB_oe,
    output logic       RDY,
    output logic       IRQ_L
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_WAIT  = 1'b1;
    localparam logic [2:0]  WS       = 3'(WAIT_STATES);
    localparam logic [16:0] RAM_SIZE = 17'(2 ** RAM_AW);
    localparam logic [13:0] PER_PAGE = PERIPH_BASE[15:2];

    logic [15:0] addr;
    logic        ram_sel;
    logic        per_sel;
    logic [1:0]  off;

    assign addr    = {extABH, extABL};
    assign ram_sel = {1'b0, addr} < RAM_SIZE;
    assign per_sel = (addr[15:2] == PER_PAGE);
    assign off     = addr[1:0];

    logic [7:0] mem [0:(1 << RAM_AW) - 1];
    logic [7:0] ram_q;
    assign ram_q = mem[addr[RAM_AW-1:0]];

    logic [0:0]  state, state_nxt;
    logic [2:0]  wcnt, wcnt_nxt;
    logic [15:0] lat_addr;

    logic [7:0]  rld_lo, rld_hi;
    logic        en, ie, ar, exp_flag, irq_q;
    logic [15:0] cnt;
    logic [7:0]  per_q;

    always_comb begin
        case (off)
            2'd0:    per_q = rld_lo;
            2'd1:    per_q = rld_hi;
            2'd2:    per_q = {5'b0, ar, ie, en};
            default: per_q = {7'b0, exp_flag};
        endcase
    end

    // NOTE: every output and next-state signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        RDY       = 1'b1;
        extDB_oe  = 1'b0;
        extDB_out = 8'h00;
        if (RW) begin
            if (state == ST_WAIT) begin
                if (addr != lat_addr) begin
                    // CPU moved on mid-stall: drop the cycle, re-decode next edge
                    state_nxt = ST_IDLE;
                    wcnt_nxt  = 3'd0;
                    RDY       = 1'b0;
                end else if (wcnt == WS) begin
                    extDB_oe  = 1'b1;
                    extDB_out = ram_q;
                    state_nxt = ST_IDLE;
                    wcnt_nxt  = 3'd0;
                end else begin
                    RDY      = 1'b0;
                    wcnt_nxt = wcnt + 3'd1;
                end
            end else if (ram_sel) begin
                if (WAIT_STATES == 0) begin
                    extDB_oe  = 1'b1;
                    extDB_out = ram_q;
                end else begin
                    RDY       = 1'b0;
                    wcnt_nxt  = 3'd1;
                    state_nxt = ST_WAIT;
                end
            end else begin
                extDB_oe  = 1'b1;
                extDB_out = per_sel ? per_q : 8'hFF;
            end
        end else begin
            state_nxt = ST_IDLE;
            wcnt_nxt  = 3'd0;
        end
        if (rstAll) begin
            RDY       = 1'b1;
            extDB_oe  = 1'b0;
            extDB_out = 8'h00;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge phi2) begin
        if (rstAll) begin
            state    <= ST_IDLE;
            wcnt     <= 3'd0;
            lat_addr <= 16'h0000;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (state == ST_IDLE) lat_addr <= addr;
        end
    end

    // NOTE: RAM is deliberately not reset; only the write enable is gated by reset.
    always_ff @(posedge phi2) begin
        if (!rstAll && !RW && ram_sel) mem[addr[RAM_AW-1:0]] <= extDB_in;
    end

    logic ctrl_wr, status_clr, expire, en_new, ar_new;

    assign ctrl_wr    = per_sel && !RW && (off == 2'd2);
    assign status_clr = per_sel && (off == 2'd3) &&
                        ((RW && state == ST_IDLE) || (!RW && extDB_in[0]));
    assign expire     = en && (cnt == 16'h0000);
    assign en_new     = ctrl_wr ? extDB_in[0] : en;
    assign ar_new     = ctrl_wr ? extDB_in[2] : ar;

    always_ff @(posedge phi2) begin
        if (rstAll) begin
            rld_lo   <= 8'h00;
            rld_hi   <= 8'h00;
            en       <= 1'b0;
            ie       <= 1'b0;
            ar       <= 1'b0;
            exp_flag <= 1'b0;
            cnt      <= 16'h0000;
            irq_q    <= 1'b1;
        end else begin
            if (per_sel && !RW && off == 2'd0) rld_lo <= extDB_in;
            if (per_sel && !RW && off == 2'd1) rld_hi <= extDB_in;
            if (ctrl_wr) begin
                en <= extDB_in[0];
                ie <= extDB_in[1];
                ar <= extDB_in[2];
            end
            // Expiry sees the AR value written this cycle and overrides the EN write
            if (expire) begin
                if (ar_new) begin
                    cnt <= {rld_hi, rld_lo};
                end else begin
                    en  <= 1'b0;
                    cnt <= 16'h0000;
                end
            end else if (ctrl_wr && extDB_in[0] && !en) begin
                cnt <= {rld_hi, rld_lo};
            end else if (en && en_new) begin
                cnt <= cnt - 16'd1;
            end
            if (expire)          exp_flag <= 1'b1;
            else if (status_clr) exp_flag <= 1'b0;
            irq_q <= ~(exp_flag & ie);
        end
    end

    assign IRQ_L = irq_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: one instance per WAIT_STATES value 0..3
// sharing the bus; a vector table for single-cycle behaviour plus timer/reset sequences.
module tb_cpu_bus_responder;

    logic       phi2 = 1'b0;
    logic       rstAll;
    logic [7:0] abh, abl, din;
    logic       rw;
    logic [7:0] dout [4];
    logic       oe   [4];
    logic       rdy  [4];
    logic       irq  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 phi2 = ~phi2;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        cpu_bus_responder #(
            .RAM_AW      (10),
            .WAIT_STATES (g),
            .PERIPH_BASE (16'hD200)
        ) u_dut (
            .phi2      (phi2),
            .rstAll    (rstAll),
            .extABH    (abh),
            .extABL    (abl),
            .RW        (rw),
            .extDB_in  (din),
            .extDB_out (dout[g]),
            .extDB_oe  (oe[g]),
            .RDY       (rdy[g]),
            .IRQ_L     (irq[g])
        );
    end

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  din;
        logic        rdy;
        logic        oe;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input int i, input logic r,
                             input logic o, input logic [7:0] d);
        check($sformatf("%s.rdy", name), {7'b0, rdy[i]}, {7'b0, r});
        check($sformatf("%s.oe", name), {7'b0, oe[i]}, {7'b0, o});
        check($sformatf("%s.data", name), dout[i], d);
    endtask

    // Apply one bus cycle's inputs and settle to mid-cycle for sampling
    task automatic drive(input logic [15:0] a, input logic r, input logic [7:0] d);
        {abh, abl} = a;
        rw  = r;
        din = d;
        #4;
    endtask

    task automatic step();
        @(posedge phi2);
        #1;
    endtask

    task automatic idle();
        repeat (2) begin
            drive(16'hFFFF, 1'b0, 8'h00);
            step();
        end
    endtask

    initial begin
        vecs[0]  = '{16'h0010, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{16'h0010, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{16'h0010, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5};
        vecs[3]  = '{16'h0400, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF};
        vecs[4]  = '{16'h03FF, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00};
        vecs[5]  = '{16'h03FF, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{16'h03FF, 1'b1, 8'h00, 1'b1, 1'b1, 8'h77};
        vecs[7]  = '{16'hD200, 1'b0, 8'h34, 1'b1, 1'b0, 8'h00};
        vecs[8]  = '{16'hD201, 1'b0, 8'h12, 1'b1, 1'b0, 8'h00};
        vecs[9]  = '{16'hD200, 1'b1, 8'h00, 1'b1, 1'b1, 8'h34};
        vecs[10] = '{16'hD201, 1'b1, 8'h00, 1'b1, 1'b1, 8'h12};
        vecs[11] = '{16'hD202, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[12] = '{16'hD203, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[13] = '{16'hD204, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF};
        vecs[14] = '{16'hD1FF, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF};
        vecs[15] = '{16'h0020, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00};
        vecs[16] = '{16'h0020, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[17] = '{16'h0020, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A};
        vecs[18] = '{16'hFFFF, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[19] = '{16'hFFFF, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF};
        vecs[20] = '{16'h0010, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[21] = '{16'h0020, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[22] = '{16'h0020, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[23] = '{16'h0020, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A};

        // Reset: outputs held at reset values even with a RAM read on the bus
        rstAll = 1'b1;
        drive(16'h0010, 1'b1, 8'h00);
        check_bus("rst_ws1", 1, 1'b1, 1'b0, 8'h00);
        check_bus("rst_ws3", 3, 1'b1, 1'b0, 8'h00);
        step();
        check("rst_irq", {7'b0, irq[1]}, 8'h01);
        step();
        rstAll = 1'b0;
        idle();

        // Table on the WAIT_STATES=1 instance: RAM, boundaries, peripheral, abort
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].addr, vecs[i].rw, vecs[i].din);
            check_bus($sformatf("vec%0d", i), 1, vecs[i].rdy, vecs[i].oe, vecs[i].dout);
            step();
        end
        idle();

        // Zero wait states: same-cycle data, while WAIT_STATES=3 stalls
        drive(16'h0010, 1'b1, 8'h00);
        check_bus("ws0_read", 0, 1'b1, 1'b1, 8'hA5);
        check("ws3_first_stall", {7'b0, rdy[3]}, 8'h00);
        step();
        idle();

        // WAIT_STATES=3: exactly three stall cycles, then unmapped read without stall
        for (int k = 0; k < 3; k++) begin
            drive(16'h03FF, 1'b1, 8'h00);
            check_bus($sformatf("ws3_stall%0d", k), 3, 1'b0, 1'b0, 8'h00);
            step();
        end
        drive(16'h03FF, 1'b1, 8'h00);
        check_bus("ws3_data", 3, 1'b1, 1'b1, 8'h77);
        step();
        drive(16'h0400, 1'b1, 8'h00);
        check_bus("ws3_unmapped", 3, 1'b1, 1'b1, 8'hFF);
        step();
        idle();

        // Timer one-shot: RLD=3, CTRL=EN|IE
        drive(16'hD200, 1'b0, 8'h03); step();
        drive(16'hD201, 1'b0, 8'h00); step();
        drive(16'hD202, 1'b0, 8'h03); step();
        for (int i = 1; i <= 5; i++) begin
            drive(16'hFFFF, 1'b0, 8'h00);
            check($sformatf("t3_irq_hold%0d", i), {7'b0, irq[1]}, 8'h01);
            step();
        end
        drive(16'hD202, 1'b1, 8'h00);
        check("t3_irq_fall", {7'b0, irq[1]}, 8'h00);
        check("t3_ctrl_en_cleared", dout[1], 8'h02);
        step();
        drive(16'hD203, 1'b1, 8'h00);
        check("t3_status_set", dout[1], 8'h01);
        step();
        drive(16'hD203, 1'b1, 8'h00);
        check("t3_status_cleared", dout[1], 8'h00);
        check("t3_irq_still_low", {7'b0, irq[1]}, 8'h00);
        step();
        drive(16'hFFFF, 1'b0, 8'h00);
        check("t3_irq_release", {7'b0, irq[1]}, 8'h01);
        step();

        // Timer auto-reload: RLD=1, CTRL=EN|IE|AR -> expiry every 2 cycles
        drive(16'hD200, 1'b0, 8'h01); step();
        drive(16'hD202, 1'b0, 8'h07); step();
        drive(16'hFFFF, 1'b0, 8'h00); step();
        drive(16'hFFFF, 1'b0, 8'h00); step();
        drive(16'hD203, 1'b1, 8'h00);
        check("t4_exp_first", dout[1], 8'h01);
        step();
        drive(16'hD203, 1'b0, 8'h01);
        step();
        drive(16'hD203, 1'b1, 8'h00);
        check("t4_set_wins", dout[1], 8'h01);
        step();
        drive(16'hD203, 1'b1, 8'h00);
        check("t4_old_value", dout[1], 8'h00);
        step();
        drive(16'hD203, 1'b1, 8'h00);
        check("t4_reassert", dout[1], 8'h01);
        step();
        drive(16'hD202, 1'b0, 8'h00);
        step();
        idle();

        // Reset during a WAIT_STATES=2 stall
        drive(16'h0010, 1'b1, 8'h00);
        check("t5_stall0", {7'b0, rdy[2]}, 8'h00);
        step();
        drive(16'h0010, 1'b1, 8'h00);
        check_bus("t5_stall1", 2, 1'b0, 1'b0, 8'h00);
        rstAll = 1'b1;
        step();
        check_bus("t5_in_reset", 2, 1'b1, 1'b0, 8'h00);
        check("t5_irq", {7'b0, irq[2]}, 8'h01);
        rstAll = 1'b0;
        drive(16'h0010, 1'b1, 8'h00);
        check_bus("t5_fresh_idle", 2, 1'b0, 1'b0, 8'h00);
        step();
        idle();
        for (int r = 0; r < 4; r++) begin
            drive(16'hD200 + 16'(r), 1'b1, 8'h00);
            check($sformatf("t5_reg%0d_zero", r), dout[1], 8'h00);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
